// File: rtl/gpio_pkg.sv
// Shared constants for the GPIO input block: register map addresses and default pin count.
package gpio_pkg;

    localparam int GPIO_WIDTH_DEFAULT = 8;

    localparam logic [1:0] GPIO_ADDR_DATA = 2'd0;
    localparam logic [1:0] GPIO_ADDR_RISE = 2'd1;
    localparam logic [1:0] GPIO_ADDR_FALL = 2'd2;
    localparam logic [1:0] GPIO_ADDR_MASK = 2'd3;

endpackage

// File: rtl/gpio_in_debounce.sv
// One-bit level qualifier: accepts a synchronized input and emits the stable level plus a
// rise/fall strobe that is high in the cycle the stable level changes. GPIO_IN_DEBOUNCE_EN selects the counting filter.
module gpio_in_debounce
`ifdef GPIO_IN_DEBOUNCE_EN
#(
    parameter int DEBOUNCE_CYCLES = 16
)
`endif
(
    input  logic clk,
    input  logic rst,
    input  logic sync_in,
    output logic stable,
    output logic rise,
    output logic fall
);

    logic stable_reg;
    logic change;

`ifdef GPIO_IN_DEBOUNCE_EN
    localparam logic [15:0] COUNT_LAST = 16'(DEBOUNCE_CYCLES - 1);

    logic [15:0] count_reg;

    // The level is accepted on the cycle the counter has already seen DEBOUNCE_CYCLES-1 differing samples.
    assign change = (sync_in != stable_reg) && (count_reg == COUNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            stable_reg <= 1'b0;
            count_reg  <= '0;
        end else begin
            if ((sync_in == stable_reg) || change) begin
                count_reg <= '0;
            end else begin
                count_reg <= count_reg + 16'd1;
            end
            if (change) begin
                stable_reg <= sync_in;
            end
        end
    end
`else
    // Without filtering the stable level is just one more register behind the synchronizer.
    assign change = (sync_in != stable_reg);

    always_ff @(posedge clk) begin
        if (rst) begin
            stable_reg <= 1'b0;
        end else begin
            stable_reg <= sync_in;
        end
    end
`endif

    assign stable = stable_reg;
    assign rise   = change & sync_in;
    assign fall   = change & ~sync_in;

endmodule

// File: rtl/gpio_in.sv
// GPIO input block: per-pin synchronizer and level qualifier, edge-pending W1C registers,
// interrupt mask and a registered read port. Define GPIO_IN_DEBOUNCE_EN to enable debouncing.
module gpio_in
    import gpio_pkg::*;
#(
    parameter int WIDTH           = GPIO_WIDTH_DEFAULT,
    parameter int DEBOUNCE_CYCLES = 16
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pins,
    input  logic [1:0]       addr,
    input  logic             rd_en,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             rvalid,
    output logic             irq
);

    logic [WIDTH-1:0] sync1_reg;
    logic [WIDTH-1:0] sync2_reg;
    logic [WIDTH-1:0] stable_vec;
    logic [WIDTH-1:0] rise_vec;
    logic [WIDTH-1:0] fall_vec;

    logic [WIDTH-1:0] rise_pend_reg;
    logic [WIDTH-1:0] rise_pend_next;
    logic [WIDTH-1:0] fall_pend_reg;
    logic [WIDTH-1:0] fall_pend_next;
    logic [WIDTH-1:0] mask_reg;
    logic [WIDTH-1:0] mask_next;
    logic [WIDTH-1:0] rdata_reg;
    logic [WIDTH-1:0] rdata_next;
    logic             rvalid_reg;
    logic             irq_reg;
    logic             irq_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
        end else begin
            sync1_reg <= pins;
            sync2_reg <= sync1_reg;
        end
    end

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
`ifdef GPIO_IN_DEBOUNCE_EN
            gpio_in_debounce #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_debounce (
`else
            gpio_in_debounce u_debounce (
`endif
                .clk     (clk),
                .rst     (rst),
                .sync_in (sync2_reg[gi]),
                .stable  (stable_vec[gi]),
                .rise    (rise_vec[gi]),
                .fall    (fall_vec[gi])
            );
        end
    endgenerate

    // A new edge is ORed in after the clear, so it survives a simultaneous W1C.
    always_comb begin
        rise_pend_next = rise_pend_reg | rise_vec;
        fall_pend_next = fall_pend_reg | fall_vec;
        mask_next      = mask_reg;
        if (wr_en) begin
            case (addr)
                GPIO_ADDR_RISE: rise_pend_next = (rise_pend_reg & ~wdata) | rise_vec;
                GPIO_ADDR_FALL: fall_pend_next = (fall_pend_reg & ~wdata) | fall_vec;
                GPIO_ADDR_MASK: mask_next      = wdata;
                default:        mask_next      = mask_reg;
            endcase
        end
    end

    // Reads see the register values from before any same-cycle write.
    always_comb begin
        rdata_next = '0;
        if (rd_en) begin
            case (addr)
                GPIO_ADDR_DATA: rdata_next = stable_vec;
                GPIO_ADDR_RISE: rdata_next = rise_pend_reg;
                GPIO_ADDR_FALL: rdata_next = fall_pend_reg;
                default:        rdata_next = mask_reg;
            endcase
        end
    end

    assign irq_next = |((rise_pend_reg | fall_pend_reg) & mask_reg);

    always_ff @(posedge clk) begin
        if (rst) begin
            rise_pend_reg <= '0;
            fall_pend_reg <= '0;
            mask_reg      <= '0;
            rdata_reg     <= '0;
            rvalid_reg    <= 1'b0;
            irq_reg       <= 1'b0;
        end else begin
            rise_pend_reg <= rise_pend_next;
            fall_pend_reg <= fall_pend_next;
            mask_reg      <= mask_next;
            rdata_reg     <= rdata_next;
            rvalid_reg    <= rd_en;
            irq_reg       <= irq_next;
        end
    end

    assign rdata  = rdata_reg;
    assign rvalid = rvalid_reg;
    assign irq    = irq_reg;

endmodule

// File: tb/tb_gpio_in.sv
// Directed self-checking bench for gpio_in; expectations follow GPIO_IN_DEBOUNCE_EN when defined.
module tb_gpio_in;
    import gpio_pkg::*;

    localparam int DB = 16;
`ifdef GPIO_IN_DEBOUNCE_EN
    localparam int LAT    = DB + 2;
    localparam bit FILTER = 1'b1;
`else
    localparam int LAT    = 3;
    localparam bit FILTER = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic [7:0] pins;
    logic [1:0] addr;
    logic       rd_en;
    logic       wr_en;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       rvalid;
    logic       irq;

    int checks = 0;
    int errors = 0;

    gpio_in #(
        .WIDTH           (8),
        .DEBOUNCE_CYCLES (DB)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .pins   (pins),
        .addr   (addr),
        .rd_en  (rd_en),
        .wr_en  (wr_en),
        .wdata  (wdata),
        .rdata  (rdata),
        .rvalid (rvalid),
        .irq    (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input logic [1:0] a, output logic [7:0] d, output logic v);
        addr  = a;
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        d = rdata;
        v = rvalid;
    endtask

    task automatic do_write(input logic [1:0] a, input logic [7:0] w);
        addr  = a;
        wdata = w;
        wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; pins = 8'h05; addr = GPIO_ADDR_DATA; rd_en = 1'b1; wr_en = 1'b0; wdata = 8'h00;
        repeat (4) tick();
        checks++;
        if (rdata !== 8'h00 || rvalid !== 1'b0 || irq !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs got rdata=%h rvalid=%b irq=%b want 00 0 0", rdata, rvalid, irq);
        end
        rd_en = 1'b0;
        $display("reset: rdata=%h rvalid=%b irq=%b", rdata, rvalid, irq);
    endtask

    task automatic test_release();
        logic [7:0] d;
        logic       v;
        rst = 1'b0;
        repeat (LAT - 1) tick();
        do_read(GPIO_ADDR_DATA, d, v);
        checks++;
        if (d !== 8'h00 || v !== 1'b1) begin
            errors++;
            $display("FAIL release_data_early got %h/%b want 00/1", d, v);
        end
        do_read(GPIO_ADDR_DATA, d, v);
        checks++;
        if (d !== 8'h05) begin errors++; $display("FAIL release_data got %h want 05", d); end
        do_read(GPIO_ADDR_RISE, d, v);
        checks++;
        if (d !== 8'h05) begin errors++; $display("FAIL release_rise got %h want 05", d); end
        do_read(GPIO_ADDR_FALL, d, v);
        checks++;
        if (d !== 8'h00) begin errors++; $display("FAIL release_fall got %h want 00", d); end
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL release_irq got %b want 0", irq); end
        tick();
        checks++;
        if (rvalid !== 1'b0 || rdata !== 8'h00) begin
            errors++;
            $display("FAIL idle_read_port got %h/%b want 00/0", rdata, rvalid);
        end
        $display("release: data=05 after latency %0d", LAT);
    endtask

    task automatic test_glitch();
        logic [7:0] d;
        logic       v;
        pins = 8'h0D;
        repeat (10) tick();
        pins = 8'h05;
        repeat (LAT + 2) tick();
        do_read(GPIO_ADDR_DATA, d, v);
        checks++;
        if (d !== 8'h05) begin errors++; $display("FAIL glitch_data got %h want 05", d); end
        do_read(GPIO_ADDR_RISE, d, v);
        checks++;
        if (d !== (FILTER ? 8'h05 : 8'h0D)) begin
            errors++; $display("FAIL glitch_rise got %h want %h", d, FILTER ? 8'h05 : 8'h0D);
        end
        do_read(GPIO_ADDR_FALL, d, v);
        checks++;
        if (d !== (FILTER ? 8'h00 : 8'h08)) begin
            errors++; $display("FAIL glitch_fall got %h want %h", d, FILTER ? 8'h00 : 8'h08);
        end
        do_write(GPIO_ADDR_RISE, 8'hFF);
        do_write(GPIO_ADDR_FALL, 8'hFF);
        do_read(GPIO_ADDR_RISE, d, v);
        checks++;
        if (d !== 8'h00) begin errors++; $display("FAIL w1c_rise_all got %h want 00", d); end
        do_read(GPIO_ADDR_FALL, d, v);
        checks++;
        if (d !== 8'h00) begin errors++; $display("FAIL w1c_fall_all got %h want 00", d); end
        $display("glitch: pin3 high 10 cycles, filtered=%b", FILTER);
    endtask

    task automatic test_irq();
        logic [7:0] d;
        logic       v;
        pins = 8'h85;
        repeat (LAT + 2) tick();
        do_write(GPIO_ADDR_RISE, 8'hFF);
        do_write(GPIO_ADDR_MASK, 8'h80);
        tick();
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_idle got %b want 0", irq); end
        pins = 8'h05;
        repeat (LAT) tick();
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_same_cycle got %b want 0", irq); end
        tick();
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL irq_assert got %b want 1", irq); end
        do_read(GPIO_ADDR_FALL, d, v);
        checks++;
        if (d !== 8'h80) begin errors++; $display("FAIL irq_fall_pend got %h want 80", d); end
        do_write(GPIO_ADDR_FALL, 8'h80);
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL irq_hold got %b want 1", irq); end
        tick();
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_clear got %b want 0", irq); end
        $display("irq: pin7 fall raised and cleared irq");
    endtask

    task automatic test_w1c_collision();
        logic [7:0] d;
        logic       v;
        pins = 8'h07;
        repeat (LAT - 1) tick();
        addr  = GPIO_ADDR_RISE;
        wdata = 8'h02;
        wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
        do_read(GPIO_ADDR_RISE, d, v);
        checks++;
        if (d !== 8'h02) begin errors++; $display("FAIL w1c_collision got %h want 02", d); end
        do_write(GPIO_ADDR_RISE, 8'h01);
        do_read(GPIO_ADDR_RISE, d, v);
        checks++;
        if (d !== 8'h02) begin errors++; $display("FAIL w1c_other_bit got %h want 02", d); end
        do_write(GPIO_ADDR_RISE, 8'h02);
        do_read(GPIO_ADDR_RISE, d, v);
        checks++;
        if (d !== 8'h00) begin errors++; $display("FAIL w1c_bit1 got %h want 00", d); end
        $display("w1c: edge wins over same-cycle clear");
    endtask

    task automatic test_rw_collision();
        logic [7:0] d;
        logic       v;
        do_write(GPIO_ADDR_MASK, 8'h00);
        addr  = GPIO_ADDR_MASK;
        wdata = 8'hFF;
        rd_en = 1'b1;
        wr_en = 1'b1;
        tick();
        rd_en = 1'b0;
        wr_en = 1'b0;
        checks++;
        if (rdata !== 8'h00 || rvalid !== 1'b1) begin
            errors++; $display("FAIL rw_old_value got %h/%b want 00/1", rdata, rvalid);
        end
        do_read(GPIO_ADDR_MASK, d, v);
        checks++;
        if (d !== 8'hFF) begin errors++; $display("FAIL rw_new_value got %h want ff", d); end
        do_write(GPIO_ADDR_DATA, 8'hFF);
        do_read(GPIO_ADDR_DATA, d, v);
        checks++;
        if (d !== 8'h07) begin errors++; $display("FAIL data_write_ignored got %h want 07", d); end
        $display("rw: read returned pre-write mask");
    endtask

    task automatic test_back_to_back();
        addr  = GPIO_ADDR_DATA;
        rd_en = 1'b1;
        tick();
        checks++;
        if (rdata !== 8'h07 || rvalid !== 1'b1) begin
            errors++; $display("FAIL b2b_first got %h/%b want 07/1", rdata, rvalid);
        end
        addr = GPIO_ADDR_MASK;
        tick();
        checks++;
        if (rdata !== 8'hFF || rvalid !== 1'b1) begin
            errors++; $display("FAIL b2b_second got %h/%b want ff/1", rdata, rvalid);
        end
        rd_en = 1'b0;
        tick();
        checks++;
        if (rdata !== 8'h00 || rvalid !== 1'b0) begin
            errors++; $display("FAIL b2b_idle got %h/%b want 00/0", rdata, rvalid);
        end
        $display("back_to_back: two reads then idle");
    endtask

    task automatic test_pulse();
        logic [7:0] d;
        logic       v;
        pins = 8'h06;
        tick();
        pins = 8'h07;
        tick();
        do_read(GPIO_ADDR_DATA, d, v);
        checks++;
        if (d !== 8'h07) begin errors++; $display("FAIL pulse_before got %h want 07", d); end
        do_read(GPIO_ADDR_DATA, d, v);
        checks++;
        if (d !== (FILTER ? 8'h07 : 8'h06)) begin
            errors++; $display("FAIL pulse_low got %h want %h", d, FILTER ? 8'h07 : 8'h06);
        end
        do_read(GPIO_ADDR_DATA, d, v);
        checks++;
        if (d !== 8'h07) begin errors++; $display("FAIL pulse_after got %h want 07", d); end
        do_read(GPIO_ADDR_FALL, d, v);
        checks++;
        if (d !== (FILTER ? 8'h00 : 8'h01)) begin
            errors++; $display("FAIL pulse_fall got %h want %h", d, FILTER ? 8'h00 : 8'h01);
        end
        do_read(GPIO_ADDR_RISE, d, v);
        checks++;
        if (d !== (FILTER ? 8'h00 : 8'h01)) begin
            errors++; $display("FAIL pulse_rise got %h want %h", d, FILTER ? 8'h00 : 8'h01);
        end
        checks++;
        if (irq !== !FILTER) begin errors++; $display("FAIL pulse_irq got %b want %b", irq, !FILTER); end
        do_write(GPIO_ADDR_RISE, 8'hFF);
        do_write(GPIO_ADDR_FALL, 8'hFF);
        $display("pulse: 1-cycle low on pin0, filtered=%b", FILTER);
    endtask

    task automatic test_mid_reset();
        logic [7:0] d;
        logic       v;
        pins = 8'h0F;
        repeat (2) tick();
        rst = 1'b1;
        repeat (2) tick();
        checks++;
        if (rdata !== 8'h00 || rvalid !== 1'b0 || irq !== 1'b0) begin
            errors++; $display("FAIL midrst_outputs got %h/%b/%b want 00/0/0", rdata, rvalid, irq);
        end
        rst = 1'b0;
        repeat (LAT - 1) tick();
        do_read(GPIO_ADDR_DATA, d, v);
        checks++;
        if (d !== 8'h00) begin errors++; $display("FAIL midrst_data_early got %h want 00", d); end
        do_read(GPIO_ADDR_DATA, d, v);
        checks++;
        if (d !== 8'h0F) begin errors++; $display("FAIL midrst_data got %h want 0f", d); end
        do_read(GPIO_ADDR_RISE, d, v);
        checks++;
        if (d !== 8'h0F) begin errors++; $display("FAIL midrst_rise got %h want 0f", d); end
        do_read(GPIO_ADDR_MASK, d, v);
        checks++;
        if (d !== 8'h00) begin errors++; $display("FAIL midrst_mask got %h want 00", d); end
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL midrst_irq got %b want 0", irq); end
        $display("mid_reset: full latency after release, rise=0f");
    endtask

    initial begin
        test_reset();
        test_release();
        test_glitch();
        test_irq();
        test_w1c_collision();
        test_rw_collision();
        test_back_to_back();
        test_pulse();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
